otf_converter: RTL and testbench

OTF_CONVERTER -- requirements
Module: otf_converter

---
 rtl/otf_pkg.sv | 17 +
 rtl/otf_digit_append.sv | 13 +
 rtl/otf_converter.sv | 144 ++++++++++++++
 tb/tb_otf_converter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/otf_pkg.sv
// Shared definitions for the on-the-fly quotient converter: FSM states and digit legality.
package otf_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONVERT  = 2'd1,
    WAIT_REM = 2'd2
  } otf_state_e;

  // Legal redundant digits span -r/2..r/2 for r = 2^radix_log2.
  function automatic logic digit_legal(input int radix_log2, input int d);
    int half;
    half = 1 << (radix_log2 - 1);
    return (d >= -half) && (d <= half);
  endfunction

endpackage

// File: rtl/otf_digit_append.sv
// Combinational append of one radix-2^RADIX_LOG2 digit offset onto a selected source register.
module otf_digit_append #(
  parameter int WIDTH      = 8,
  parameter int RADIX_LOG2 = 1
) (
  input  logic [WIDTH-1:0]      src_i,
  input  logic [RADIX_LOG2-1:0] offset_i,
  output logic [WIDTH-1:0]      next_o
);

  assign next_o = {src_i[WIDTH-RADIX_LOG2-1:0], offset_i};

endmodule

// File: rtl/otf_converter.sv
// On-the-fly redundant-digit to binary quotient converter with remainder-sign correction.
// Optional rounding register QPr and RoundUp input are enabled by defining OTF_ROUND_EN.
module otf_converter
  import otf_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RADIX_LOG2 = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  DigitValid,
  input  logic [RADIX_LOG2:0]   Digit,
  input  logic                  RemValid,
  input  logic                  SignRemainder,
`ifdef OTF_ROUND_EN
  input  logic                  RoundUp,
`endif
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic [WIDTH-1:0]      Q
);

  localparam int NDIG = WIDTH / RADIX_LOG2;
  localparam int CW   = $clog2(NDIG + 1);
  localparam int R    = 1 << RADIX_LOG2;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  otf_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] qr_q, qmr_q, q_q;
  logic [WIDTH-1:0] qr_d, qmr_d;
  logic             busy_q, done_q, error_q;

  logic signed [31:0]    d_int;
  logic                  d_legal;
  logic [RADIX_LOG2-1:0] off_q, off_qm;
  logic [WIDTH-1:0]      qr_src, qmr_src, q_sel;

  assign d_int   = 32'($signed(Digit));
  assign d_legal = digit_legal(RADIX_LOG2, d_int);

  // Offsets d, d-1 (and d+1) modulo r are exactly the low RADIX_LOG2 bits.
  assign off_q   = Digit[RADIX_LOG2-1:0];
  assign off_qm  = Digit[RADIX_LOG2-1:0] - RADIX_LOG2'(1);
  assign qr_src  = (d_int >= 0) ? qr_q : qmr_q;
  assign qmr_src = (d_int > 0)  ? qr_q : qmr_q;

  otf_digit_append #(.WIDTH(WIDTH), .RADIX_LOG2(RADIX_LOG2)) u_qr (
    .src_i(qr_src), .offset_i(off_q), .next_o(qr_d)
  );

  otf_digit_append #(.WIDTH(WIDTH), .RADIX_LOG2(RADIX_LOG2)) u_qmr (
    .src_i(qmr_src), .offset_i(off_qm), .next_o(qmr_d)
  );

`ifdef OTF_ROUND_EN
  logic [WIDTH-1:0]      qpr_q, qpr_d, qpr_src;
  logic [RADIX_LOG2-1:0] off_qp;

  assign off_qp  = Digit[RADIX_LOG2-1:0] + RADIX_LOG2'(1);
  assign qpr_src = (d_int <= R - 2) ? qr_q : qpr_q;

  otf_digit_append #(.WIDTH(WIDTH), .RADIX_LOG2(RADIX_LOG2)) u_qpr (
    .src_i(qpr_src), .offset_i(off_qp), .next_o(qpr_d)
  );

  always_comb begin
    q_sel = qr_q;
    if (RoundUp) q_sel = SignRemainder ? qr_q  : qpr_q;
    else         q_sel = SignRemainder ? qmr_q : qr_q;
  end
`else
  assign q_sel = SignRemainder ? qmr_q : qr_q;
`endif

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      qr_q    <= '0;
      qmr_q   <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef OTF_ROUND_EN
      qpr_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            qr_q    <= '0;
            qmr_q   <= '1;
`ifdef OTF_ROUND_EN
            qpr_q   <= WIDTH'(1);
`endif
            cnt_q   <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          if (DigitValid) begin
            if (d_legal) begin
              qr_q  <= qr_d;
              qmr_q <= qmr_d;
`ifdef OTF_ROUND_EN
              qpr_q <= qpr_d;
`endif
              cnt_q <= cnt_q + CW'(1);
              if (cnt_q == LAST) state_q <= WAIT_REM;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        WAIT_REM: begin
          if (RemValid) begin
            q_q     <= q_sel;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Error = error_q;
  assign Q     = q_q;

endmodule

// File: tb/tb_otf_converter.sv
// Directed self-checking bench: radix-2 and radix-4 converter instances driven side by side.
module tb_otf_converter;

  logic Clk;
  logic Reset;

  logic       r2_start, r2_dv, r2_rem, r2_sign, r2_round;
  logic [1:0] r2_digit;
  logic       r2_busy, r2_done, r2_err;
  logic [7:0] r2_q;

  logic       r4_start, r4_dv, r4_rem, r4_sign, r4_round;
  logic [2:0] r4_digit;
  logic       r4_busy, r4_done, r4_err;
  logic [7:0] r4_q;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] r2_seq [8];
  logic [2:0] r4_seq [4];

  otf_converter #(.WIDTH(8), .RADIX_LOG2(1)) dut2 (
    .Clk(Clk), .Reset(Reset), .Start(r2_start), .DigitValid(r2_dv), .Digit(r2_digit),
    .RemValid(r2_rem), .SignRemainder(r2_sign),
`ifdef OTF_ROUND_EN
    .RoundUp(r2_round),
`endif
    .Busy(r2_busy), .Done(r2_done), .Error(r2_err), .Q(r2_q)
  );

  otf_converter #(.WIDTH(8), .RADIX_LOG2(2)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(r4_start), .DigitValid(r4_dv), .Digit(r4_digit),
    .RemValid(r4_rem), .SignRemainder(r4_sign),
`ifdef OTF_ROUND_EN
    .RoundUp(r4_round),
`endif
    .Busy(r4_busy), .Done(r4_done), .Error(r4_err), .Q(r4_q)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic r2_feed(input logic [1:0] d);
    r2_dv = 1'b1; r2_digit = d; tick(); r2_dv = 1'b0;
  endtask

  task automatic r4_feed(input logic [2:0] d);
    r4_dv = 1'b1; r4_digit = d; tick(); r4_dv = 1'b0;
  endtask

  task automatic r2_begin();
    r2_start = 1'b1; tick(); r2_start = 1'b0;
  endtask

  task automatic r4_begin();
    r4_start = 1'b1; tick(); r4_start = 1'b0;
  endtask

  task automatic r2_finish(input logic sign);
    r2_rem = 1'b1; r2_sign = sign; tick(); r2_rem = 1'b0;
  endtask

  task automatic r4_finish(input logic sign);
    r4_rem = 1'b1; r4_sign = sign; tick(); r4_rem = 1'b0;
  endtask

  initial begin
    r2_seq = '{2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 2'b11};
    r4_seq = '{3'b010, 3'b111, 3'b000, 3'b001};
    Reset = 1'b1;
    r2_start = 0; r2_dv = 0; r2_rem = 0; r2_sign = 0; r2_round = 0; r2_digit = '0;
    r4_start = 0; r4_dv = 0; r4_rem = 0; r4_sign = 0; r4_round = 0; r4_digit = '0;
    tick(); tick();

    // Reset state.
    check_bit ("rst_busy2", r2_busy, 1'b0);
    check_bit ("rst_done2", r2_done, 1'b0);
    check_bit ("rst_err2",  r2_err,  1'b0);
    check_byte("rst_q2",    r2_q,    8'h00);
    check_bit ("rst_busy4", r4_busy, 1'b0);
    check_byte("rst_q4",    r4_q,    8'h00);
    Reset = 1'b0;
    tick();

    // Radix-2, positive remainder.
    r2_begin();
    check_bit("r2_busy_start", r2_busy, 1'b1);
    for (int i = 0; i < 8; i++) r2_feed(r2_seq[i]);
    check_bit("r2_busy_waitrem", r2_busy, 1'b1);
    check_bit("r2_nodone_early", r2_done, 1'b0);
    r2_finish(1'b0);
    check_bit ("r2_done_pos", r2_done, 1'b1);
    check_byte("r2_q_pos",    r2_q,    8'h71);
    tick();
    check_bit ("r2_done_clr", r2_done, 1'b0);
    check_bit ("r2_idle",     r2_busy, 1'b0);
    check_byte("r2_q_hold",   r2_q,    8'h71);

    // Radix-2, negative remainder; Q must hold through the run.
    r2_begin();
    for (int i = 0; i < 4; i++) r2_feed(r2_seq[i]);
    check_byte("r2_q_midrun", r2_q, 8'h71);
    for (int i = 4; i < 8; i++) r2_feed(r2_seq[i]);
    r2_finish(1'b1);
    check_bit ("r2_done_neg", r2_done, 1'b1);
    check_byte("r2_q_neg",    r2_q,    8'h70);

    // Radix-2 illegal code -2 is discarded and flagged.
    r2_begin();
    r2_feed(2'b10);
    check_bit("r2_err_illegal", r2_err, 1'b1);
    for (int i = 0; i < 8; i++) r2_feed(r2_seq[i]);
    r2_finish(1'b0);
    check_byte("r2_q_after_illegal", r2_q, 8'h71);

    // Radix-4 basic.
    r4_begin();
    for (int i = 0; i < 4; i++) r4_feed(r4_seq[i]);
    r4_finish(1'b0);
    check_bit ("r4_done_pos", r4_done, 1'b1);
    check_byte("r4_q_pos",    r4_q,    8'h71);
    tick();

`ifdef OTF_ROUND_EN
    r4_round = 1'b1;
    r4_begin();
    for (int i = 0; i < 4; i++) r4_feed(r4_seq[i]);
    r4_finish(1'b0);
    check_byte("r4_q_roundup", r4_q, 8'h72);
    r4_round = 1'b0;
    r2_round = 1'b1;
    r2_begin();
    for (int i = 0; i < 8; i++) r2_feed(r2_seq[i]);
    r2_finish(1'b1);
    check_byte("r2_q_roundup_neg", r2_q, 8'h71);
    r2_round = 1'b0;
    tick();
`endif

    // Radix-4 illegal digit 3 between 2nd and 3rd legal digits.
    r4_begin();
    r4_feed(r4_seq[0]);
    r4_feed(r4_seq[1]);
    check_bit("r4_err_before", r4_err, 1'b0);
    r4_feed(3'b011);
    check_bit("r4_err_set", r4_err, 1'b1);
    r4_feed(r4_seq[2]);
    check_bit("r4_busy_3dig", r4_busy, 1'b1);
    r4_feed(r4_seq[3]);
    r4_finish(1'b0);
    check_bit ("r4_done_err", r4_done, 1'b1);
    check_byte("r4_q_err",    r4_q,    8'h71);
    check_bit ("r4_err_sticky", r4_err, 1'b1);
    tick();
    r4_begin();
    check_bit("r4_err_cleared", r4_err, 1'b0);

    // Reset mid-run after two digits.
    r4_feed(r4_seq[0]);
    r4_feed(r4_seq[1]);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_bit ("r4_rst_busy", r4_busy, 1'b0);
    check_byte("r4_rst_q",    r4_q,    8'h00);
    check_bit ("r4_rst_done", r4_done, 1'b0);
    r4_begin();
    for (int i = 0; i < 4; i++) r4_feed(r4_seq[i]);
    r4_finish(1'b0);
    check_byte("r4_q_after_rst", r4_q, 8'h71);
    tick();

    // Stall, Start and RemValid while busy, digit in WAIT_REM: all ignored.
    r4_begin();
    r4_feed(r4_seq[0]);
    r4_feed(r4_seq[1]);
    r4_digit = 3'b001;
    r4_start = 1'b1; r4_rem = 1'b1;
    tick();
    r4_start = 1'b0; r4_rem = 1'b0;
    tick(); tick();
    check_bit("r4_stall_busy", r4_busy, 1'b1);
    check_bit("r4_stall_done", r4_done, 1'b0);
    r4_feed(r4_seq[2]);
    r4_feed(r4_seq[3]);
    r4_feed(3'b001);
    tick();
    check_bit("r4_waitrem_busy", r4_busy, 1'b1);
    check_bit("r4_waitrem_done", r4_done, 1'b0);
    r4_finish(1'b0);
    check_bit ("r4_stall_done_pulse", r4_done, 1'b1);
    check_byte("r4_q_stall",  r4_q,   8'h71);
    check_bit ("r4_stall_err", r4_err, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
